// File: rtl/puf_pkg.sv
// puf_pkg: shared FSM state type and timing constants for the RO PUF response generator.
// Declarations only: no latency and no flow control of its own.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_COUNT   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } puf_state_e;

    // SETTLE length matches synchronizer depth so the chain is refilled from the new channel.
    localparam int SETTLE_CYC = 2;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/puf_edge_cnt.sv
// puf_edge_cnt: RO synchronizer + rising-edge detect + clear/enable counter; RO-to-count 3 cycles, no backpressure.
// PUF_CNT_SAT_EN: counter saturates at all-ones and sat_o flags each dropped edge; otherwise it wraps.
module puf_edge_cnt
    import puf_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
`ifdef PUF_CNT_SAT_EN
    ,
    output logic             sat_o
`endif
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  rise;

    // prev is zeroed during clear, so a channel already high at window start counts once.
    assign rise = sync_q[SYNC_DEPTH-1] & ~prev_q;

`ifdef PUF_CNT_SAT_EN
    logic at_max;

    assign at_max = &cnt_q;
    assign sat_o  = en_i & ~clr_i & rise & at_max;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && rise) begin
`ifdef PUF_CNT_SAT_EN
            if (!at_max) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`else
            cnt_d = cnt_q + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], ro_i};
            prev_q <= clr_i ? 1'b0 : sync_q[SYNC_DEPTH-1];
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/puf_ro_resp_gen.sv
// puf_ro_resp_gen: RO-pair PUF response generator; o_valid RESP_BITS*(WIN_CYCLES+3)+1 cycles after accepted start.
// No backpressure (o_valid is a one-cycle pulse); PUF_CNT_SAT_EN adds saturating counters and the o_sat port.
module puf_ro_resp_gen
    import puf_pkg::*;
#(
    parameter int N_RO         = 16,
    parameter int RESP_BITS    = 8,
    parameter int CNT_BIT_SIZE = 12,
    parameter int WIN_CYCLES   = 1024,
    parameter int SEL_W        = $clog2(N_RO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_start,
    input  logic [SEL_W-1:0]     i_challenge,
    input  logic [N_RO-1:0]      i_ro,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [RESP_BITS-1:0] o_response,
    output logic                 o_tie
`ifdef PUF_CNT_SAT_EN
    ,
    output logic                 o_sat
`endif
);

    localparam int K_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int PH_W = (WIN_CYCLES > SETTLE_CYC) ? $clog2(WIN_CYCLES) : $clog2(SETTLE_CYC);

    puf_state_e           state_q, state_d;
    logic [PH_W-1:0]      ph_q, ph_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [SEL_W-1:0]     base_q, base_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic                 tie_q, tie_d;

    logic [SEL_W-1:0]        sel_a, sel_b;
    logic                    ro_a, ro_b;
    logic                    cnt_clr, cnt_en;
    logic [CNT_BIT_SIZE-1:0] cnt_a, cnt_b;

    // Pair indices wrap naturally by truncation to SEL_W bits.
    assign sel_a = base_q + SEL_W'({k_q, 1'b0});
    assign sel_b = sel_a + SEL_W'(1);
    assign ro_a  = i_ro[sel_a];
    assign ro_b  = i_ro[sel_b];

    assign cnt_clr = (state_q == ST_SETTLE);
    assign cnt_en  = (state_q == ST_COUNT);

`ifdef PUF_CNT_SAT_EN
    logic sat_a, sat_b;
    logic sat_q, sat_d;
`endif

    puf_edge_cnt #(
        .CNT_W (CNT_BIT_SIZE)
    ) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .ro_i  (ro_a),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt_a)
`ifdef PUF_CNT_SAT_EN
        ,
        .sat_o (sat_a)
`endif
    );

    puf_edge_cnt #(
        .CNT_W (CNT_BIT_SIZE)
    ) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .ro_i  (ro_b),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt_b)
`ifdef PUF_CNT_SAT_EN
        ,
        .sat_o (sat_b)
`endif
    );

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        k_d     = k_q;
        base_d  = base_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
`ifdef PUF_CNT_SAT_EN
        sat_d   = sat_q;
`endif
        // Dropping enable abandons the evaluation; partial response bits are kept.
        if (state_q != ST_IDLE && !i_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start && i_en) begin
                        state_d = ST_SETTLE;
                        ph_d    = '0;
                        k_d     = '0;
                        base_d  = i_challenge;
                        resp_d  = '0;
                        tie_d   = 1'b0;
`ifdef PUF_CNT_SAT_EN
                        sat_d   = 1'b0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (ph_q == PH_W'(SETTLE_CYC - 1)) begin
                        state_d = ST_COUNT;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                ST_COUNT: begin
`ifdef PUF_CNT_SAT_EN
                    sat_d = sat_q | sat_a | sat_b;
`endif
                    if (ph_q == PH_W'(WIN_CYCLES - 1)) begin
                        state_d = ST_COMPARE;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                ST_COMPARE: begin
                    resp_d[k_q] = (cnt_a > cnt_b);
                    if (cnt_a == cnt_b) begin
                        tie_d = 1'b1;
                    end
                    if (k_q == K_W'(RESP_BITS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + K_W'(1);
                        ph_d    = '0;
                        state_d = ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            k_q     <= '0;
            base_q  <= '0;
            resp_q  <= '0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            k_q     <= k_d;
            base_q  <= base_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
        end
    end

`ifdef PUF_CNT_SAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign o_sat = sat_q;
`endif

    assign o_busy     = (state_q != ST_IDLE);
    assign o_valid    = (state_q == ST_DONE);
    assign o_response = resp_q;
    assign o_tie      = tie_q;

endmodule
